// File: rtl/shared_reg_pkg.sv
// Shared types and default sizes for the shared register arbiter.
package shared_reg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ACK   = 2'd2
  } state_t;

  localparam int NUM_REQ_DEF = 4;
  localparam int DATA_W_DEF  = 8;

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational round-robin picker: lowest requesting index >= ptr, wrapping to 0.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  logic [N-1:0] ge_ptr;
  logic [N-1:0] masked;
  logic [N-1:0] sel;
  logic [N-1:0] first;
  logic [N-1:0] bit_mask [IW];

  genvar gi, bi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_ge
      assign ge_ptr[gi] = (ptr <= IW'(gi));
    end
    // bit_mask[b] marks every position whose index has bit b set.
    for (bi = 0; bi < IW; bi++) begin : g_enc
      for (gi = 0; gi < N; gi++) begin : g_bit
        assign bit_mask[bi][gi] = (((gi >> bi) & 1) == 1);
      end
      assign idx[bi] = |(first & bit_mask[bi]);
    end
  endgenerate

  // Prefer requests at or above the pointer; fall back to the wrapped set.
  assign masked = req & ge_ptr;
  assign sel    = (|masked) ? masked : req;
  assign first  = sel & (~sel + 1'b1);
  assign valid  = |req;

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter sharing one register among NUM_REQ writers.
// Optional parity (q_par/par_err) enabled by SHARED_REG_PARITY_EN.
module shared_reg_arbiter
  import shared_reg_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      ack,
  output logic [IDX_W-1:0]          owner,
  output logic [DATA_W-1:0]         q,
  output logic                      busy
`ifdef SHARED_REG_PARITY_EN
  ,
  output logic                      q_par,
  output logic                      par_err
`endif
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   win_reg, win_next;
  logic [IDX_W-1:0]   ptr_reg, ptr_next;
  logic [IDX_W-1:0]   owner_reg;
  logic [DATA_W-1:0]  q_reg;
  logic               wr_en;
  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic [DATA_W-1:0]  slice [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign slice[gi] = wdata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  rr_pick #(.N(NUM_REQ), .IW(IDX_W)) u_pick (
    .req   (req),
    .ptr   (ptr_reg),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    state_next = state_reg;
    win_next   = win_reg;
    ptr_next   = ptr_reg;
    wr_en      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          win_next   = pick_idx;
          state_next = GRANT;
        end
      end
      GRANT: begin
        // A dropped request aborts without touching q, owner or the pointer.
        if (req[win_reg]) begin
          wr_en      = 1'b1;
          ptr_next   = (win_reg == LAST_IDX) ? '0 : win_reg + 1'b1;
          state_next = ACK;
        end else begin
          state_next = IDLE;
        end
      end
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      win_reg   <= '0;
      ptr_reg   <= '0;
      owner_reg <= '0;
      q_reg     <= '0;
    end else begin
      state_reg <= state_next;
      win_reg   <= win_next;
      ptr_reg   <= ptr_next;
      if (wr_en) begin
        q_reg     <= slice[win_reg];
        owner_reg <= win_reg;
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (state_reg == GRANT) gnt[win_reg] = 1'b1;
  end

  assign ack   = (state_reg == ACK);
  assign busy  = (state_reg != IDLE);
  assign owner = owner_reg;
  assign q     = q_reg;

`ifdef SHARED_REG_PARITY_EN
  logic q_par_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_par_reg <= 1'b0;
    end else if (wr_en) begin
      q_par_reg <= ^slice[win_reg];
    end
  end

  assign q_par   = q_par_reg;
  assign par_err = (^q_reg) != q_par_reg;
`endif

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Scoreboard bench for shared_reg_arbiter (4 requesters, 8-bit data).
module tb_shared_reg_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  gnt;
  logic        ack;
  logic [1:0]  owner;
  logic [7:0]  q;
  logic        busy;
`ifdef SHARED_REG_PARITY_EN
  logic        q_par;
  logic        par_err;
`endif

  typedef struct packed {
    logic [1:0] owner;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  shared_reg_arbiter dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .wdata (wdata),
    .gnt   (gnt),
    .ack   (ack),
    .owner (owner),
    .q     (q),
    .busy  (busy)
`ifdef SHARED_REG_PARITY_EN
    ,
    .q_par   (q_par),
    .par_err (par_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_slice(input int i, input logic [7:0] v);
    wdata[i*8 +: 8] = v;
  endtask

  // Write monitor: pops the scoreboard on each ack and checks grant legality.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (gnt != 4'b0000 || ack) begin
        vectors++;
        if (((gnt & (gnt - 4'b0001)) != 4'b0000) || (gnt != 4'b0000 && ack)) begin
          miscompares++;
          $display("FAIL gnt_protocol: gnt=%b ack=%b, required one-hot gnt and never with ack", gnt, ack);
        end
      end
      if (ack) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_ack: owner=%0d q=%h, required no write", owner, q);
        end else begin
          e = sb.pop_front();
          $display("txn: owner=%0d q=%h (expected owner=%0d q=%h)", owner, q, e.owner, e.data);
          if (q !== e.data || owner !== e.owner) begin
            miscompares++;
            $display("FAIL write: owner=%0d q=%h, required owner=%0d q=%h", owner, q, e.owner, e.data);
          end
        end
      end
    end
  end

  task automatic test_reset;
    req = 4'b1111;
    set_slice(0, 8'h11); set_slice(1, 8'h22); set_slice(2, 8'h33); set_slice(3, 8'h44);
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      cyc(1);
      vectors++;
      if (q !== 8'h00 || gnt !== 4'b0000 || ack !== 1'b0 || busy !== 1'b0 || owner !== 2'd0) begin
        miscompares++;
        $display("FAIL reset_state: q=%h gnt=%b ack=%b busy=%b owner=%0d, required all zero",
                 q, gnt, ack, busy, owner);
      end
    end
    rst = 1'b0;
    cyc(1);
    vectors++;
    if (gnt !== 4'b0001 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_first_gnt: gnt=%b busy=%b, required gnt=0001 busy=1", gnt, busy);
    end
    req = 4'b0001;
    sb.push_back('{owner: 2'd0, data: 8'h11});
    cyc(1);
    req = 4'b0000;
    cyc(1);
  endtask

  task automatic test_single_write;
    set_slice(2, 8'hA5);
    req = 4'b0100;
    cyc(1);
    vectors++;
    if (gnt !== 4'b0100) begin
      miscompares++;
      $display("FAIL single_gnt: gnt=%b, required 0100", gnt);
    end
    sb.push_back('{owner: 2'd2, data: 8'hA5});
    // Other requesters' data must not reach q.
    set_slice(0, 8'($urandom)); set_slice(1, 8'($urandom)); set_slice(3, 8'($urandom));
    cyc(1);
    vectors++;
    if (ack !== 1'b1 || q !== 8'hA5 || owner !== 2'd2) begin
      miscompares++;
      $display("FAIL single_ack: ack=%b q=%h owner=%0d, required ack=1 q=a5 owner=2", ack, q, owner);
    end
    req = 4'b0000;
    cyc(1);
    vectors++;
    if (busy !== 1'b0 || ack !== 1'b0 || gnt !== 4'b0000) begin
      miscompares++;
      $display("FAIL single_idle: busy=%b ack=%b gnt=%b, required 0/0/0000", busy, ack, gnt);
    end
  endtask

  task automatic test_fairness;
    logic [7:0] vals [4];
    logic [3:0] eg;
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
    for (int i = 0; i < 4; i++) set_slice(i, vals[i]);
    rst = 1'b1;
    req = 4'b1111;
    cyc(1);
    rst = 1'b0;
    for (int t = 0; t < 5; t++) sb.push_back('{owner: 2'(t % 4), data: vals[t % 4]});
    for (int t = 0; t < 5; t++) begin
      eg = 4'b0001 << (t % 4);
      cyc(1);
      vectors++;
      if (gnt !== eg) begin
        miscompares++;
        $display("FAIL fair_gnt[%0d]: gnt=%b, required %b", t, gnt, eg);
      end
      cyc(1);
      vectors++;
      if (ack !== 1'b1 || owner !== 2'(t % 4) || q !== vals[t % 4]) begin
        miscompares++;
        $display("FAIL fair_ack[%0d]: ack=%b owner=%0d q=%h, required 1/%0d/%h",
                 t, ack, owner, q, t % 4, vals[t % 4]);
      end
      if (t == 4) req = 4'b0000;
      cyc(1);
      vectors++;
      if (busy !== 1'b0 || ack !== 1'b0) begin
        miscompares++;
        $display("FAIL fair_gap[%0d]: busy=%b ack=%b, required 0/0", t, busy, ack);
      end
    end
  endtask

  task automatic test_ptr_wrap;
    req = 4'b1000;
    cyc(1);
    sb.push_back('{owner: 2'd3, data: 8'h44});
    cyc(1);
    req = 4'b1001;
    cyc(1);
    cyc(1);
    vectors++;
    if (gnt !== 4'b0001) begin
      miscompares++;
      $display("FAIL wrap_first: gnt=%b, required 0001", gnt);
    end
    sb.push_back('{owner: 2'd0, data: 8'h11});
    cyc(1);
    req = 4'b1000;
    cyc(1);
    cyc(1);
    vectors++;
    if (gnt !== 4'b1000) begin
      miscompares++;
      $display("FAIL wrap_second: gnt=%b, required 1000", gnt);
    end
    sb.push_back('{owner: 2'd3, data: 8'h44});
    cyc(1);
    req = 4'b0000;
    cyc(1);
  endtask

  task automatic test_abort;
    set_slice(1, 8'h5A);
    req = 4'b0010;
    cyc(1);
    vectors++;
    if (gnt !== 4'b0010) begin
      miscompares++;
      $display("FAIL abort_gnt: gnt=%b, required 0010", gnt);
    end
    req = 4'b0000;
    cyc(1);
    vectors++;
    if (ack !== 1'b0 || busy !== 1'b0 || q !== 8'h44 || owner !== 2'd3) begin
      miscompares++;
      $display("FAIL abort_state: ack=%b busy=%b q=%h owner=%0d, required 0/0/44/3", ack, busy, q, owner);
    end
    // Pointer must still be 0, so requester 0 wins over everyone.
    req = 4'b1111;
    cyc(1);
    vectors++;
    if (gnt !== 4'b0001) begin
      miscompares++;
      $display("FAIL abort_ptr: gnt=%b, required 0001", gnt);
    end
    req = 4'b0000;
    cyc(1);
  endtask

  task automatic test_reset_mid;
    set_slice(2, 8'h07);
    req = 4'b0100;
    cyc(1);
    rst = 1'b1;
    cyc(1);
    vectors++;
    if (q !== 8'h00 || gnt !== 4'b0000 || ack !== 1'b0 || owner !== 2'd0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: q=%h gnt=%b ack=%b owner=%0d busy=%b, required all zero",
               q, gnt, ack, owner, busy);
    end
    rst = 1'b0;
    cyc(1);
    vectors++;
    if (gnt !== 4'b0100) begin
      miscompares++;
      $display("FAIL reset_mid_regnt: gnt=%b, required 0100", gnt);
    end
    sb.push_back('{owner: 2'd2, data: 8'h07});
    cyc(1);
`ifdef SHARED_REG_PARITY_EN
    vectors++;
    if (q_par !== 1'b1 || par_err !== 1'b0) begin
      miscompares++;
      $display("FAIL parity: q_par=%b par_err=%b, required 1/0", q_par, par_err);
    end
`endif
    req = 4'b0000;
    cyc(1);
  endtask

  initial begin
    int guard;
    test_reset();
    test_single_write();
    test_fairness();
    test_ptr_wrap();
    test_abort();
    test_reset_mid();
    guard = 0;
    while (sb.size() != 0 && guard < 10) begin
      cyc(1);
      guard++;
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d writes outstanding, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
